// File: rtl/register_file_multiport.sv
// Multi-read, dual-write register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_multiport #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32,
   parameter int READ_PORTS = 2,
   parameter int ZERO_REG   = 1,
   localparam int AW = $clog2(REG_COUNT),
   localparam int CW = $clog2(REG_COUNT + 1)
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic [READ_PORTS*AW-1:0]         readIndex,
   output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
   output logic [READ_PORTS-1:0]            readPending,
   input  logic [1:0]                       writeEnable,
   input  logic [2*AW-1:0]                  writeIndex,
   input  logic [2*DATA_WIDTH-1:0]          writeData,
   input  logic                             reserveEnable,
   input  logic [AW-1:0]                    reserveIndex,
   output logic [CW-1:0]                    pendingCount
);

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic [REG_COUNT-1:0]  pend;
   logic [REG_COUNT-1:0]  pend_next;
   logic [CW-1:0]         count_next;

   logic [AW-1:0]         wr_idx [2];
   logic [DATA_WIDTH-1:0] wr_data [2];
   logic [1:0]            wr_ok;
   logic                  res_ok;
   logic [AW-1:0]         rd_idx [READ_PORTS];

   // Writes and reservations aimed at a hardwired zero register are dropped up front.
   always_comb begin
      for (int l = 0; l < 2; l++) begin
         wr_idx[l]  = writeIndex[l*AW +: AW];
         wr_data[l] = writeData[l*DATA_WIDTH +: DATA_WIDTH];
         wr_ok[l]   = writeEnable[l] && !((ZERO_REG != 0) && (wr_idx[l] == '0));
      end
      res_ok = reserveEnable && !((ZERO_REG != 0) && (reserveIndex == '0));
   end

   // A reservation marks a newer producer, so it beats a retiring write to the same register.
   always_comb begin
      pend_next = pend;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (res_ok && (reserveIndex == AW'(i))) begin
            pend_next[i] = 1'b1;
         end else if ((wr_ok[0] && (wr_idx[0] == AW'(i))) ||
                      (wr_ok[1] && (wr_idx[1] == AW'(i)))) begin
            pend_next[i] = 1'b0;
         end
      end
   end

   always_comb begin
      count_next = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         count_next = count_next + CW'(pend_next[i]);
      end
   end

   // Lane 1 is assigned last so it wins a same-index collision.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (wr_ok[0]) regs[wr_idx[0]] <= wr_data[0];
         if (wr_ok[1]) regs[wr_idx[1]] <= wr_data[1];
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pend         <= '0;
         pendingCount <= '0;
      end else begin
         pend         <= pend_next;
         pendingCount <= count_next;
      end
   end

   always_comb begin
      readData    = '0;
      readPending = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         rd_idx[p] = readIndex[p*AW +: AW];
         readData[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx[p]];
         readPending[p] = pend[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
         if (wr_ok[1] && (wr_idx[1] == rd_idx[p])) begin
            readData[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[1];
            readPending[p] = res_ok && (reserveIndex == rd_idx[p]);
         end else if (wr_ok[0] && (wr_idx[0] == rd_idx[p])) begin
            readData[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[0];
            readPending[p] = res_ok && (reserveIndex == rd_idx[p]);
         end
`endif
         if (((ZERO_REG != 0) && (rd_idx[p] == '0)) || !resetN) begin
            readData[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            readPending[p] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_register_file_multiport.sv
// Self-checking bench for register_file_multiport: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_register_file_multiport;
   localparam int DW = 32;
   localparam int RC = 32;
   localparam int RP = 2;
   localparam int AW = 5;
   localparam int CW = 6;

   logic            clk = 1'b0;
   logic            resetN;
   logic [RP*AW-1:0] readIndex;
   logic [RP*DW-1:0] readData;
   logic [RP-1:0]   readPending;
   logic [1:0]      writeEnable;
   logic [2*AW-1:0] writeIndex;
   logic [2*DW-1:0] writeData;
   logic            reserveEnable;
   logic [AW-1:0]   reserveIndex;
   logic [CW-1:0]   pendingCount;

   logic [1:0]    we;
   logic [AW-1:0] wi0, wi1, ri, rp0, rp1;
   logic [DW-1:0] wd0, wd1;
   logic          res;

   assign writeEnable   = we;
   assign writeIndex    = {wi1, wi0};
   assign writeData     = {wd1, wd0};
   assign reserveEnable = res;
   assign reserveIndex  = ri;
   assign readIndex     = {rp1, rp0};

   always #5 clk = ~clk;

   register_file_multiport #(
      .DATA_WIDTH(DW), .REG_COUNT(RC), .READ_PORTS(RP), .ZERO_REG(1)
   ) dut (
      .clk(clk), .resetN(resetN),
      .readIndex(readIndex), .readData(readData), .readPending(readPending),
      .writeEnable(writeEnable), .writeIndex(writeIndex), .writeData(writeData),
      .reserveEnable(reserveEnable), .reserveIndex(reserveIndex),
      .pendingCount(pendingCount)
   );

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] m_reg [RC];
   bit            m_pend [RC];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < RC; i++) begin
         m_reg[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < RC; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] idx);
      if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we[1] && wi1 == idx) return wd1;
      if (we[0] && wi0 == idx) return wd0;
`endif
      return m_reg[idx];
   endfunction

   function automatic logic exp_pend(input logic [AW-1:0] idx);
      if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if ((we[1] && wi1 == idx) || (we[0] && wi0 == idx)) return res && (ri == idx);
`endif
      return m_pend[idx];
   endfunction

   function automatic void model_edge();
      if (we[0] && wi0 != 0) m_reg[wi0] = wd0;
      if (we[1] && wi1 != 0) m_reg[wi1] = wd1;
      if (we[0]) m_pend[wi0] = 1'b0;
      if (we[1]) m_pend[wi1] = 1'b0;
      if (res && ri != 0) m_pend[ri] = 1'b1;
   endfunction

   task automatic idle();
      we = 2'b00; res = 1'b0;
      wi0 = '0; wi1 = '0; wd0 = '0; wd1 = '0; ri = '0;
   endtask

   // Inputs are set after a negedge; outputs are compared just before the next posedge.
   task automatic cycle(input string tag);
      #1;
      chk($sformatf("%s_rd0", tag), 64'(readData[0 +: DW]), 64'(exp_data(rp0)));
      chk($sformatf("%s_rd1", tag), 64'(readData[DW +: DW]), 64'(exp_data(rp1)));
      chk($sformatf("%s_pd0", tag), 64'(readPending[0]), 64'(exp_pend(rp0)));
      chk($sformatf("%s_pd1", tag), 64'(readPending[1]), 64'(exp_pend(rp1)));
      chk($sformatf("%s_cnt", tag), 64'(pendingCount), 64'(model_count()));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      idle();
      rp0 = 5'd3; rp1 = 5'd7;
      resetN = 1'b0;
      #3;
      chk("por_rd0", 64'(readData[0 +: DW]), 64'h0);
      chk("por_pend", 64'(readPending), 64'h0);
      chk("por_cnt", 64'(pendingCount), 64'h0);
      @(negedge clk);
      resetN = 1'b1;
      cycle("idle");

      // Dual-lane collision: lane 1 wins
      we = 2'b11; wi0 = 5'd5; wd0 = 32'hDEADBEEF; wi1 = 5'd5; wd1 = 32'h12345678;
      cycle("t2_coll");
      idle(); rp0 = 5'd5;
      #1 chk("t2_lane1_wins", 64'(readData[0 +: DW]), 64'h12345678);
      cycle("t2_rd");
      we = 2'b01; wi0 = 5'd0; wd0 = 32'hFFFFFFFF;
      cycle("t2_wr0");
      idle(); rp0 = 5'd0;
      #1 chk("t2_r0_zero", 64'(readData[0 +: DW]), 64'h0);
      cycle("t2_rd0");

      // Reserve then retire r7
      res = 1'b1; ri = 5'd7;
      cycle("t3_res");
      idle(); rp0 = 5'd7;
      #1 chk("t3_cnt1", 64'(pendingCount), 64'd1);
      chk("t3_pend7", 64'(readPending[0]), 64'd1);
      cycle("t3_hold");
      we = 2'b01; wi0 = 5'd7; wd0 = 32'hA5;
      cycle("t3_wr");
      idle(); rp0 = 5'd7;
      #1 chk("t3_cnt0", 64'(pendingCount), 64'd0);
      chk("t3_data", 64'(readData[0 +: DW]), 64'hA5);
      cycle("t3_rd");

      // Reserve and write the same pending register in one cycle
      res = 1'b1; ri = 5'd3;
      cycle("t4_res");
      res = 1'b1; ri = 5'd3; we = 2'b01; wi0 = 5'd3; wd0 = 32'h55;
      cycle("t4_both");
      idle(); rp1 = 5'd3;
      #1 chk("t4_cnt", 64'(pendingCount), 64'd1);
      chk("t4_pend", 64'(readPending[1]), 64'd1);
      chk("t4_data", 64'(readData[DW +: DW]), 64'h55);
      we = 2'b01; wi0 = 5'd3; wd0 = 32'h66;
      cycle("t4_clr");

      // Two reservations then a dual retire
      idle(); res = 1'b1; ri = 5'd1;
      cycle("t5_r1");
      #1 chk("t5_cnt1", 64'(pendingCount), 64'd1);
      res = 1'b1; ri = 5'd2;
      cycle("t5_r2");
      #1 chk("t5_cnt2", 64'(pendingCount), 64'd2);
      res = 1'b0; we = 2'b11; wi0 = 5'd1; wd0 = 32'h11; wi1 = 5'd2; wd1 = 32'h22;
      cycle("t5_wr");
      idle();
      #1 chk("t5_cnt0", 64'(pendingCount), 64'd0);

      // Same-cycle write and read of r9
      we = 2'b01; wi0 = 5'd9; wd0 = 32'h77; rp0 = 5'd9;
`ifdef REGFILE_BYPASS_EN
      #1 chk("t6_bypass", 64'(readData[0 +: DW]), 64'h77);
`else
      #1 chk("t6_nobypass", 64'(readData[0 +: DW]), 64'h0);
`endif
      cycle("t6_wr");
      idle();

      // Asynchronous reset in the middle of activity
      we = 2'b11; wi0 = 5'd4; wd0 = 32'h1111; wi1 = 5'd6; wd1 = 32'h2222; res = 1'b1; ri = 5'd8;
      cycle("t1_load");
      idle(); res = 1'b1; ri = 5'd10; rp0 = 5'd4; rp1 = 5'd8;
      cycle("t1_res");
      idle();
      #2 resetN = 1'b0;
      #1 chk("t1_rd0", 64'(readData[0 +: DW]), 64'h0);
      chk("t1_rd1", 64'(readData[DW +: DW]), 64'h0);
      chk("t1_pend", 64'(readPending), 64'h0);
      chk("t1_cnt", 64'(pendingCount), 64'h0);
      model_clear();
      we = 2'b01; wi0 = 5'd4; wd0 = 32'hABC; res = 1'b1; ri = 5'd4;
      @(posedge clk);
      @(negedge clk);
      #1 chk("t1_held_rd0", 64'(readData[0 +: DW]), 64'h0);
      chk("t1_held_cnt", 64'(pendingCount), 64'h0);
      idle();
      resetN = 1'b1;
      cycle("t1_post");

      // Randomized traffic concentrated on a few registers to force collisions
      for (int n = 0; n < 400; n++) begin
         we  = 2'($urandom);
         wi0 = AW'($urandom_range(0, 7));
         wi1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         wd0 = $urandom;
         wd1 = $urandom;
         res = ($urandom_range(0, 2) != 0);
         ri  = AW'($urandom_range(0, 7));
         rp0 = AW'($urandom_range(0, 7));
         rp1 = AW'($urandom);
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
